// File: rtl/tnn_seq_ternary_neuron.sv
// Sequential ternary-weighted neuron: accumulates N_IN activations one per beat,
// then offers the signed sum and its threshold decision over a valid/ready pair.
module tnn_seq_ternary_neuron #(
    parameter int IN_W     = 2,
    parameter int N_IN     = 4,
    parameter int DROP_LSB = 0,
    parameter int ACC_W    = IN_W + $clog2(N_IN) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2*N_IN-1:0]   cfg_weights,
    input  logic [ACC_W-1:0]    cfg_threshold,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_W-1:0]     in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_bit,
    output logic [ACC_W-1:0]    out_sum
);

    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] sum_q, sum_d;
    logic                    bit_q, bit_d;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] acc_nx;
    logic signed [ACC_W-1:0] thr_s;
    logic [1:0]              wcode;
    logic                    beat;

    // Approximate activation: clear the DROP_LSB low bits, then zero-extend.
    function automatic logic signed [ACC_W-1:0] truncate_act(input logic [IN_W-1:0] a);
        logic [IN_W-1:0] m;
        m = a & ({IN_W{1'b1}} << DROP_LSB);
        return signed'({{(ACC_W-IN_W){1'b0}}, m});
    endfunction

    assign in_ready  = rst_n && (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign out_bit   = bit_q;
    assign out_sum   = sum_q;

    assign beat  = in_valid && in_ready;
    assign wcode = cfg_weights[{idx_q, 1'b0} +: 2];
    assign term  = truncate_act(in_data);
    assign thr_s = signed'(cfg_threshold);

    always_comb begin
        case (wcode)
            2'b01:   acc_nx = acc_q + term;
            2'b11:   acc_nx = acc_q - term;
            default: acc_nx = acc_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        bit_d   = bit_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (beat) begin
                    acc_d = acc_nx;
                    if (idx_q == LAST_IDX) begin
                        sum_d   = acc_nx;
                        bit_d   = (acc_nx >= thr_s);
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ACCUM;
                    end
                end
            end
            DONE: begin
                // Decision is held until taken; the accumulator restarts from zero.
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            bit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            bit_q   <= bit_d;
        end
    end

endmodule

// File: tb/tb_tnn_seq_ternary_neuron.sv
// Bench for tnn_seq_ternary_neuron: directed and random vectors against a
// dot-product reference, plus small instances for the DROP_LSB and N_IN corners.
module tb_tnn_seq_ternary_neuron;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    // Main instance: defaults (IN_W=2, N_IN=4, ACC_W=5)
    logic [7:0]        cfg_weights;
    logic signed [4:0] cfg_threshold;
    logic              in_valid, in_ready, out_valid, out_ready, out_bit;
    logic [1:0]        in_data;
    logic signed [4:0] out_sum;

    // DROP_LSB=1 instance
    logic [7:0]        d_w;
    logic signed [4:0] d_thr, d_sum;
    logic              d_iv, d_ir, d_ov, d_or, d_bit;
    logic [1:0]        d_data;

    // N_IN=1, IN_W=3 instance (ACC_W=4)
    logic [1:0]        a_w;
    logic signed [3:0] a_thr, a_sum;
    logic              a_iv, a_ir, a_ov, a_or, a_bit;
    logic [2:0]        a_data;

    // N_IN=8, IN_W=4 instance (ACC_W=8)
    logic [15:0]       b_w;
    logic signed [7:0] b_thr, b_sum;
    logic              b_iv, b_ir, b_ov, b_or, b_bit;
    logic [3:0]        b_data;

    int          vd[8];
    logic [15:0] vw;
    int          vthr;
    int          exp_sum, exp_bit;

    tnn_seq_ternary_neuron dut (
        .clk(clk), .rst_n(rst_n), .cfg_weights(cfg_weights), .cfg_threshold(cfg_threshold),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit), .out_sum(out_sum)
    );

    tnn_seq_ternary_neuron #(.IN_W(2), .N_IN(4), .DROP_LSB(1)) dut_drop (
        .clk(clk), .rst_n(rst_n), .cfg_weights(d_w), .cfg_threshold(d_thr),
        .in_valid(d_iv), .in_ready(d_ir), .in_data(d_data),
        .out_valid(d_ov), .out_ready(d_or), .out_bit(d_bit), .out_sum(d_sum)
    );

    tnn_seq_ternary_neuron #(.IN_W(3), .N_IN(1)) dut_n1 (
        .clk(clk), .rst_n(rst_n), .cfg_weights(a_w), .cfg_threshold(a_thr),
        .in_valid(a_iv), .in_ready(a_ir), .in_data(a_data),
        .out_valid(a_ov), .out_ready(a_or), .out_bit(a_bit), .out_sum(a_sum)
    );

    tnn_seq_ternary_neuron #(.IN_W(4), .N_IN(8)) dut_n8 (
        .clk(clk), .rst_n(rst_n), .cfg_weights(b_w), .cfg_threshold(b_thr),
        .in_valid(b_iv), .in_ready(b_ir), .in_data(b_data),
        .out_valid(b_ov), .out_ready(b_or), .out_bit(b_bit), .out_sum(b_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wval(input logic [1:0] c);
        if (c == 2'b01) return 1;
        if (c == 2'b11) return -1;
        return 0;
    endfunction

    // Reference: ternary dot product of the first n activations after dropping low bits.
    function automatic int ref_sum(input int n, input int drop);
        int s;
        logic [1:0] c;
        s = 0;
        for (int i = 0; i < n; i++) begin
            c = vw[2*i +: 2];
            s += wval(c) * ((vd[i] >> drop) << drop);
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Feed one vector to the main instance; gaps holds 4-bit bubble counts per beat.
    task automatic run_main(input string tag, input int gaps, input int bubble_pct);
        exp_sum = ref_sum(4, 0);
        exp_bit = (exp_sum >= vthr) ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < ((gaps >> (4*i)) & 15); g++) begin
                @(negedge clk); in_valid = 1'b0; in_data = 2'($urandom);
            end
            while (bubble_pct > 0 && $urandom_range(0, 99) < bubble_pct) begin
                @(negedge clk); in_valid = 1'b0; in_data = 2'($urandom);
            end
            @(negedge clk);
            chk({tag, "_rdy"}, in_ready, 1);
            chk({tag, "_ov_early"}, out_valid, 0);
            in_valid      = 1'b1;
            in_data       = 2'(vd[i]);
            cfg_weights   = vw[7:0];
            cfg_threshold = 5'(vthr);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_ov"}, out_valid, 1);
        chk({tag, "_sum"}, out_sum, exp_sum);
        chk({tag, "_bit"}, out_bit, exp_bit);
        chk({tag, "_ir_done"}, in_ready, 0);
    endtask

    // Hold the decision for stall cycles with in_valid high, then take it.
    task automatic take_main(input string tag, input int stall);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 2'($urandom);
            chk({tag, "_hold_ov"}, out_valid, 1);
            chk({tag, "_hold_sum"}, out_sum, exp_sum);
            chk({tag, "_hold_ir"}, in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, "_rel_ov"}, out_valid, 0);
        chk({tag, "_rel_ir"}, in_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_weights = '0; cfg_threshold = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        d_w = '0; d_thr = '0; d_iv = 1'b0; d_data = '0; d_or = 1'b0;
        a_w = '0; a_thr = '0; a_iv = 1'b0; a_data = '0; a_or = 1'b0;
        b_w = '0; b_thr = '0; b_iv = 1'b0; b_data = '0; b_or = 1'b0;
        vw = '0; vthr = 0;

        repeat (2) @(negedge clk);
        chk("rst_ov", out_valid, 0);
        chk("rst_sum", out_sum, 0);
        chk("rst_bit", out_bit, 0);
        chk("rst_ir", in_ready, 0);
        rst_n = 1'b1;
        #1 chk("rel_ir", in_ready, 1);

        // All +1, beats 3,1,2,0: sum 6 against thresholds 6 and 7
        vd = '{3, 1, 2, 0, 0, 0, 0, 0}; vw = 16'h0055; vthr = 6;
        run_main("t1a", 0, 0);
        take_main("t1a", 0);
        vthr = 7;
        run_main("t1b", 0, 0);
        take_main("t1b", 0);

        vd = '{3, 3, 3, 1, 0, 0, 0, 0}; vw = 16'h004D; vthr = 2;
        run_main("t2mix", 0, 0);
        take_main("t2mix", 0);
        vd = '{3, 3, 3, 3, 0, 0, 0, 0}; vw = 16'h00FF; vthr = -12;
        run_main("t2neg", 0, 0);
        take_main("t2neg", 0);
        vd = '{2, 3, 1, 3, 0, 0, 0, 0}; vw = 16'h00AA; vthr = 0;
        run_main("t2zero", 0, 0);
        take_main("t2zero", 0);

        // Bubbles 1,0,0,1,1,0,1, then a 5-cycle stall, then a fresh vector from zero
        vd = '{2, 1, 3, 3, 0, 0, 0, 0}; vw = 16'h0075; vthr = 1;
        run_main("t3gap", 32'h1020, 0);
        take_main("t3stall", 5);
        vd = '{1, 0, 2, 1, 0, 0, 0, 0}; vw = 16'h0055; vthr = 4;
        run_main("t3next", 0, 0);
        take_main("t3next", 0);

        // Reset after two beats discards the partial sum
        @(negedge clk); in_valid = 1'b1; in_data = 2'd3; cfg_weights = 8'h55;
        @(negedge clk); in_data = 2'd3;
        @(negedge clk); in_valid = 1'b0; rst_n = 1'b0;
        #1 chk("t5_rst_ir", in_ready, 0);
        @(negedge clk);
        chk("t5_rst_ov", out_valid, 0);
        chk("t5_rst_sum", out_sum, 0);
        rst_n = 1'b1;
        #1 chk("t5_rel_ir", in_ready, 1);
        vd = '{1, 1, 1, 1, 0, 0, 0, 0}; vw = 16'h0055; vthr = 4;
        run_main("t5fresh", 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_done_rst_ov", out_valid, 0);
        rst_n = 1'b1;

        // DROP_LSB=1: beats 3,1,2,1 all +1 -> 2+0+2+0
        vd = '{3, 1, 2, 1, 0, 0, 0, 0}; vw = 16'h0055; vthr = 5;
        exp_sum = ref_sum(4, 1);
        d_w = 8'h55; d_thr = 5'sd5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); d_iv = 1'b1; d_data = 2'(vd[i]);
        end
        @(negedge clk); d_iv = 1'b0;
        chk("t4_ov", d_ov, 1);
        chk("t4_sum", d_sum, exp_sum);
        chk("t4_bit", d_bit, (exp_sum >= vthr) ? 1 : 0);
        d_or = 1'b1;
        @(negedge clk); d_or = 1'b0;

        // N_IN=1: single beat goes straight to DONE
        a_w = 2'b01; a_thr = 4'sd7;
        @(negedge clk);
        chk("t6a_ov_pre", a_ov, 0);
        a_iv = 1'b1; a_data = 3'd7;
        @(negedge clk); a_iv = 1'b0;
        chk("t6a_ov", a_ov, 1);
        chk("t6a_sum", a_sum, 7);
        chk("t6a_bit", a_bit, 1);
        a_or = 1'b1;
        @(negedge clk); a_or = 1'b0;

        // N_IN=8, IN_W=4, all -1, beats 15
        vd = '{15, 15, 15, 15, 15, 15, 15, 15}; vw = 16'hFFFF; vthr = -120;
        exp_sum = ref_sum(8, 0);
        b_w = vw; b_thr = 8'(vthr);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t6b_ov_pre", b_ov, 0);
            b_iv = 1'b1; b_data = 4'(vd[i]);
        end
        @(negedge clk); b_iv = 1'b0;
        chk("t6b_ov", b_ov, 1);
        chk("t6b_sum", b_sum, exp_sum);
        chk("t6b_bit", b_bit, 1);
        b_or = 1'b1;
        @(negedge clk); b_or = 1'b0;

        // Random vectors with random bubbles and stalls
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < 4; i++) vd[i] = int'($urandom_range(0, 3));
            vw   = 16'($urandom);
            vthr = int'($urandom_range(0, 26)) - 13;
            run_main("rnd", 0, 30);
            take_main("rnd", int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
